// File: rtl/xor_gate_unit_pkg.sv
// Shared ALU package.
// Purpose: holds the datapath width and the ALU opcode encoding so that every
// ALU unit agrees on them.
// Contents:
//   XLEN      - native register width of the datapath (64).
//   alu_op_e  - ALU operation select; ALU_XOR routes XOR/XORI to xor_gate_unit.
//   tree_leaves - number of leaves of a balanced binary reduction tree that
//                 covers a given number of inputs (next power of two).
package xor_gate_unit_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Leaves needed by a balanced binary tree over n inputs; unused leaves are
  // tied to 0 so they never affect an OR reduction.
  function automatic int tree_leaves(input int n);
    int p;
    p = 1;
    while (p < n) p = p * 2;
    return p;
  endfunction

endpackage : xor_gate_unit_pkg

// File: rtl/xor_gate_unit_xor_bit.sv
// Single-bit XOR cell, the leaf element of xor_gate_unit.
// Ports:
//   a - operand bit A
//   b - operand bit B
//   o - a ^ b (X/Z propagate with normal XOR semantics)
module xor_bit (
  input  logic a,
  input  logic b,
  output logic o
);

  assign o = a ^ b;

endmodule : xor_bit

// File: rtl/xor_gate_unit.sv
// 64-bit bitwise XOR unit for the ALU (XOR/XORI).
// Builds the result from WIDTH single-bit xor_bit cells, derives a zero flag
// through an OR tree plus one inversion, and keeps a registered copy for
// pipelined consumers.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset; clears only the registered outputs
//   en       - capture enable for the registered result
//   x, y     - operands
//   final_c  - combinational result x ^ y ("final" is a reserved word in
//              SystemVerilog, so the combinational result carries a _c tag)
//   zero     - combinational flag, high when final_c == 0
//   final_q  - registered copy of final_c
//   zero_q   - registered copy of zero
//   valid_q  - high for the cycle after a capture
//
// valid/capture semantics: on a rising clk edge with en=1 the current final_c
// and zero are captured into final_q/zero_q and valid_q goes high for exactly
// the following cycle; with en=0 the data registers hold and valid_q drops.
// There is no back-pressure: consumers must take the data while valid_q=1.
module xor_gate_unit
  import xor_gate_unit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] final_c,
  output logic             zero,
  output logic [WIDTH-1:0] final_q,
  output logic             zero_q,
  output logic             valid_q
);

  localparam int LEAVES = tree_leaves(WIDTH);
  localparam int NODES  = 2 * LEAVES - 1;

  // Bitwise XOR from one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    xor_bit u_xor_bit (
      .a (x[i]),
      .b (y[i]),
      .o (final_c[i])
    );
  end

  // OR reduction as a heap-ordered binary tree: node k has children 2k+1 and
  // 2k+2, leaves live at LEAVES-1 .. NODES-1, root is node 0.
  logic [NODES-1:0] or_node;

  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < WIDTH) begin : g_used
      assign or_node[LEAVES-1+j] = final_c[j];
    end else begin : g_pad
      assign or_node[LEAVES-1+j] = 1'b0;
    end
  end

  for (genvar k = 0; k < LEAVES - 1; k++) begin : g_or
    assign or_node[k] = or_node[2*k+1] | or_node[2*k+2];
  end

  assign zero = ~or_node[0];

  // Register stage: reset takes effect immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_q <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        final_q <= final_c;
        zero_q  <= zero;
      end
    end
  end

endmodule : xor_gate_unit

// File: tb/tb_xor_gate_unit.sv
// Directed self-checking bench for xor_gate_unit.
module tb_xor_gate_unit;

  localparam int W = 64;

  localparam logic [W-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] OP_A  = 64'h1334_5678_4ACB_CF77;
  localparam logic [W-1:0] OP_B  = 64'hFEEC_B209_8755_D301;
  localparam logic [W-1:0] A_X_B = 64'hEDD8_E471_CD9E_1C76;

  logic         clk;
  logic         clk_run;
  logic         rst_n;
  logic         en;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] final_c;
  logic         zero;
  logic [W-1:0] final_q;
  logic         zero_q;
  logic         valid_q;

  int tests;
  int fails;

  xor_gate_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .x       (x),
    .y       (y),
    .final_c (final_c),
    .zero    (zero),
    .final_q (final_q),
    .zero_q  (zero_q),
    .valid_q (valid_q)
  );

  // Clock / reset block: the clock only toggles while clk_run is set so the
  // combinational checks can be made with the clock idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    clk_run = 1'b0;
    rst_n   = 1'b0;
    en      = 1'b0;
    x       = '0;
    y       = '0;

    // Reset state, clock idle.
    #1;
    check ("rst_final_q", final_q, '0);
    check1("rst_zero_q",  zero_q,  1'b0);
    check1("rst_valid_q", valid_q, 1'b0);
    check ("zz_final",    final_c, '0);
    check1("zz_zero",     zero,    1'b1);

    // Combinational vectors with no clock running.
    x = 64'd1; y = 64'd1; #2;
    check ("one_final", final_c, '0);
    check1("one_zero",  zero,    1'b1);

    x = ONES; y = ONES; #2;
    check ("ones_final", final_c, '0);
    check1("ones_zero",  zero,    1'b1);

    y = '0; #2;
    check ("ones0_final", final_c, ONES);
    check1("ones0_zero",  zero,    1'b0);

    x = 64'h8000_0000_0000_0000; y = '0; #2;
    check ("msb_final", final_c, 64'h8000_0000_0000_0000);
    check1("msb_zero",  zero,    1'b0);

    x = OP_A; y = OP_B; #2;
    check ("ab_final", final_c, A_X_B);
    check1("ab_zero",  zero,    1'b0);

    // Registered path.
    rst_n   = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check ("cap_final_q", final_q, A_X_B);
    check1("cap_zero_q",  zero_q,  1'b0);
    check1("cap_valid_q", valid_q, 1'b1);

    @(negedge clk);
    en = 1'b0;
    x  = '0;  // operands change while not capturing
    @(posedge clk); #1;
    check ("hold_final_q", final_q, A_X_B);
    check1("hold_zero_q",  zero_q,  1'b0);
    check1("hold_valid_q", valid_q, 1'b0);
    check ("hold_final",   final_c, OP_B);

    @(negedge clk);
    en = 1'b1;
    x  = OP_B;
    @(posedge clk); #1;
    check ("capz_final_q", final_q, '0);
    check1("capz_zero_q",  zero_q,  1'b1);
    check1("capz_valid_q", valid_q, 1'b1);

    @(negedge clk);
    x = 64'h0000_0000_0000_00F0;
    y = 64'h0000_0000_0000_000F;
    @(posedge clk); #1;
    check ("cap2_final_q", final_q, 64'h0000_0000_0000_00FF);
    check1("cap2_zero_q",  zero_q,  1'b0);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check ("arst_final_q", final_q, '0);
    check1("arst_zero_q",  zero_q,  1'b0);
    check1("arst_valid_q", valid_q, 1'b0);
    check ("arst_final",   final_c, 64'h0000_0000_0000_00FF);

    // Registers stay cleared across an edge while reset is held with en=1.
    @(posedge clk); #1;
    check ("hrst_final_q", final_q, '0);
    check1("hrst_valid_q", valid_q, 1'b0);

    // Release reset; first capture happens on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    x = OP_A; y = OP_B;
    @(posedge clk); #1;
    check ("rel_final_q", final_q, A_X_B);
    check1("rel_valid_q", valid_q, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #5000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule : tb_xor_gate_unit

// File: doc/xor_gate_unit.md
# xor_gate_unit

64-bit bitwise XOR unit for the sequential RISC-V datapath. It serves the ALU's XOR/XORI operations. It provides an immediate combinational result and a registered copy for pipelined consumers. It also provides a zero flag. The unit is built structurally from single-bit XOR cells so that it matches the gate-level style of the rest of the ALU.

## Interface
Parameters:
- WIDTH, 64, operand and result width in bits.

Ports:
- clk  input  1  system clock; the unit has one clock.
- rst_n  input  1  reset, asynchronous and active-low; clears all registered outputs.
- en  input  1  capture enable for the registered result.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- final  output  WIDTH  combinational result x ^ y.
- zero  output  1  combinational flag, high when final == 0.
- final_q  output  WIDTH  registered copy of final.
- zero_q  output  1  registered copy of zero.
- valid_q  output  1  high for the cycle after a capture.

## Operation
- final[i] = x[i] XOR y[i] for every bit i in 0..WIDTH-1.
  - No carries and no sign handling; the result is purely bitwise.
- zero = NOR-reduction of final.
- final and zero depend only on x and y.
  - They must be valid with clk idle and rst_n at any value, so that purely combinational use works with no clock toggling.
- Registered path, on the rising edge of clk with en=1:
  - final_q <= final.
  - zero_q <= zero.
  - valid_q <= 1.
- Registered path, on the rising edge of clk with en=0:
  - final_q and zero_q hold their values.
  - valid_q <= 0.
- X/Z inputs propagate per standard XOR semantics; no masking.

## Timing
- final and zero: zero-cycle latency, pure combinational path from x and y.
- final_q, zero_q and valid_q: one-cycle latency from x, y and en sampled at the rising clk edge.
- Reset:
  - rst_n low immediately forces final_q=0, zero_q=0 and valid_q=0, without waiting for clk.
  - Combinational outputs are unaffected by reset.
- Reset deassertion takes effect at the next rising edge; the first capture can occur on that edge if en=1.
- Reset asserted mid-operation discards the pending capture; the registers stay cleared while rst_n=0.
- When x and y change in the same cycle as en, the edge captures the values present at that edge.

## Structure
- Shared ALU package: constant XLEN=64 (default for WIDTH), and the ALU opcode enum entry selecting XOR.
- Sub-module xor_bit: 1-bit cell with inputs a and b and output o = a ^ b.
  - Instantiate WIDTH copies in a generate loop.
  - Build the zero reduction as a tree of OR cells followed by a final inversion.
- The register stage is local to this unit.

## Test plan
- x=0, y=0 -> final=0, zero=1.
- x=0x0000000000000001, y=0x0000000000000001 -> final=0, zero=1.
- x=0xFFFFFFFFFFFFFFFF, y=0xFFFFFFFFFFFFFFFF -> final=0, zero=1.
  - Then y=0 -> final=0xFFFFFFFFFFFFFFFF, zero=0.
- x=0x133456784ACBCF77, y=0xFEECB2098755D301 -> final=0xEDD8E471CD9E1C76, zero=0.
  - Check within 10 ns with no clock running.
- Registered path:
  - Apply the previous operands with en=1 and clock once -> final_q=0xEDD8E471CD9E1C76, valid_q=1.
  - Next edge with en=0 -> final_q unchanged, valid_q=0.
- Drop rst_n between clock edges -> final_q=0, zero_q=0, valid_q=0 immediately, while final still shows x^y.
